// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states, oversample default, parity/stop encodings and data-size decode
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int OVERSAMPLE_DEF = 16;
  localparam logic PAR_EVEN = 1'b1;
  localparam logic [1:0] STOP_2 = 2'd2;
  function automatic logic [3:0] data_bits(input logic [3:0] size);
    return (size >= 4'd6 && size <= 4'd8) ? size : 4'd9;
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop rx synchronizer (rx_o) and bit value (bit_o), a 2-of-3 tick vote when UART_RX_MAJORITY_EN is defined
module uart_rx_sampler (
  input  logic clk_i,
  input  logic rst_i,
`ifdef UART_RX_MAJORITY_EN
  input  logic clk_en_i,
`endif
  input  logic rx_i,
  output logic rx_o,
  output logic bit_o
);
  logic [1:0] sync;
  always_ff @(posedge clk_i) sync <= rst_i ? 2'b11 : {sync[0], rx_i};
  assign rx_o = sync[1];
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge clk_i) hist <= rst_i ? 2'b11 : clk_en_i ? {hist[0], rx_o} : hist;
  assign bit_o = (hist[1] & hist[0]) | (hist[1] & rx_o) | (hist[0] & rx_o);
`else
  assign bit_o = rx_o;
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with ready/valid word output, parity/frame/overrun flags; UART_RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_en_i,
  input  logic       en_i,
  input  logic       rx_i,
  input  logic [3:0] data_size_i,
  input  logic       parity_size_i,
  input  logic       parity_type_i,
  input  logic [1:0] stop_size_i,
  output logic [8:0] data_o,
  output logic       data_valid_o,
  input  logic       data_ready_i,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       rx_busy_o
);
  localparam int CW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1 + LAT);
  localparam logic [CW-1:0] BIT_PT = CW'(OVERSAMPLE - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt, nbits;
  logic [8:0] shift;
  logic par_en, par_type, stop2, stop_cnt, par_acc, par_err, frm_err, done;
  logic rx_s, bit_s;
  uart_rx_sampler u_sampler (
    .clk_i,
    .rst_i,
`ifdef UART_RX_MAJORITY_EN
    .clk_en_i,
`endif
    .rx_i,
    .rx_o (rx_s),
    .bit_o(bit_s)
  );
  assign rx_busy_o = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      nbits <= 4'd8;
      shift <= '0;
      par_en <= 1'b0;
      par_type <= 1'b0;
      stop2 <= 1'b0;
      stop_cnt <= 1'b0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      done <= 1'b0;
      data_o <= '0;
      data_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (done) begin
        data_o <= shift >> (4'd9 - nbits);
        parity_err_o <= par_err;
        frame_err_o <= frm_err;
        overrun_o <= data_valid_o && !data_ready_i;
        data_valid_o <= 1'b1;
      end else if (data_ready_i) begin
        data_valid_o <= 1'b0;
      end
      if (clk_en_i) begin
        case (state)
          IDLE: if (en_i && !rx_s) begin
            nbits <= data_bits(data_size_i);
            par_en <= parity_size_i;
            par_type <= parity_type_i;
            stop2 <= stop_size_i >= STOP_2;
            cnt <= '0;
            stop_cnt <= 1'b0;
            par_acc <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
            state <= START;
          end
          START: if (cnt == START_PT) begin
            cnt <= '0;
            bit_cnt <= '0;
            state <= bit_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == BIT_PT) begin
            cnt <= '0;
            shift <= {bit_s, shift[8:1]};
            par_acc <= par_acc ^ bit_s;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == nbits - 1'b1) state <= par_en ? PARITY : STOP;
          end else cnt <= cnt + 1'b1;
          PARITY: if (cnt == BIT_PT) begin
            cnt <= '0;
            par_err <= bit_s != (par_type == PAR_EVEN ? par_acc : ~par_acc);
            state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == BIT_PT) begin
            cnt <= '0;
            frm_err <= frm_err | ~bit_s;
            stop_cnt <= 1'b1;
            if (!stop2 || stop_cnt) begin
              state <= IDLE;
              done <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
